mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 115 +++++++++++
 tb/tb_mem_stage.sv | 122 ++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with a 256 x 32 data memory.
// Aligned stores commit at the clock edge and are counted.
// Loads read the array combinationally, and the word is captured into MEM/WB.
// A misaligned load or store is dropped and raises a sticky error flag.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  dstn_ex_mm,
  input  logic [31:0] y_ex_mm,
  input  logic [31:0] foutput2_ex_mm,
  input  logic        MemRead_ex_mm,
  input  logic        MemWrite_ex_mm,
  input  logic        MemtoReg_ex_mm,
  input  logic        RegWrite_ex_mm,
  output logic [4:0]  dstn_mm_wb,
  output logic [31:0] y_mm_wb,
  output logic [31:0] rdata_mm_wb,
  output logic        MemtoReg_mm_wb,
  output logic        RegWrite_mm_wb,
  output logic [31:0] wb_data,
  output logic        misalign_err,
  output logic [15:0] store_count
);

  // Word-addressed data memory; the address wraps modulo 1 KiB
  logic [31:0] mem_q [0:255];

  logic [7:0]  word_idx;
  logic        aligned;
  logic        misaligned;
  logic        store_en;
  logic [31:0] rd_word;

  logic [4:0]  dstn_q,      dstn_d;
  logic [31:0] y_q,         y_d;
  logic [31:0] rdata_q,     rdata_d;
  logic        memtoreg_q,  memtoreg_d;
  logic        regwrite_q,  regwrite_d;
  logic        misalign_q,  misalign_d;
  logic [15:0] store_cnt_q, store_cnt_d;

  // High address bits do not take part in addressing
  logic unused_addr_bits;
  assign unused_addr_bits = ^y_ex_mm[31:10];

  assign word_idx   = y_ex_mm[9:2];
  assign aligned    = (y_ex_mm[1:0] == 2'b00);
  assign misaligned = (MemRead_ex_mm | MemWrite_ex_mm) & ~aligned;
  assign store_en   = MemWrite_ex_mm & aligned;
  // Read happens before any same-cycle write, so read+write returns old data
  assign rd_word    = mem_q[word_idx];

  // Next-state logic for the MEM/WB register and the status counters
  always_comb begin
    dstn_d      = dstn_ex_mm;
    y_d         = y_ex_mm;
    memtoreg_d  = MemtoReg_ex_mm;
    rdata_d     = 32'h0;
    regwrite_d  = RegWrite_ex_mm;
    misalign_d  = misalign_q;
    store_cnt_d = store_cnt_q;
    if (MemRead_ex_mm && aligned) begin
      rdata_d = rd_word;
    end
    // Register $0 is hard-wired to zero, so never write it back
    if (dstn_ex_mm == 5'd0) begin
      regwrite_d = 1'b0;
    end
    if (misaligned) begin
      regwrite_d = 1'b0;
      misalign_d = 1'b1;
    end
    if (store_en) begin
      store_cnt_d = store_cnt_q + 16'd1;
    end
  end

  // Pipeline register; an active reset discards the instruction in MEM
  always_ff @(posedge clk) begin
    if (!reset) begin
      dstn_q      <= 5'd0;
      y_q         <= 32'h0;
      rdata_q     <= 32'h0;
      memtoreg_q  <= 1'b0;
      regwrite_q  <= 1'b0;
      misalign_q  <= 1'b0;
      store_cnt_q <= 16'h0;
    end else begin
      dstn_q      <= dstn_d;
      y_q         <= y_d;
      rdata_q     <= rdata_d;
      memtoreg_q  <= memtoreg_d;
      regwrite_q  <= regwrite_d;
      misalign_q  <= misalign_d;
      store_cnt_q <= store_cnt_d;
    end
  end

  // Memory write port; contents survive reset, but a store under reset is dropped
  always_ff @(posedge clk) begin
    if (reset && store_en) begin
      mem_q[word_idx] <= foutput2_ex_mm;
    end
  end

  assign dstn_mm_wb     = dstn_q;
  assign y_mm_wb        = y_q;
  assign rdata_mm_wb    = rdata_q;
  assign MemtoReg_mm_wb = memtoreg_q;
  assign RegWrite_mm_wb = regwrite_q;
  assign misalign_err   = misalign_q;
  assign store_count    = store_cnt_q;
  assign wb_data        = memtoreg_q ? rdata_q : y_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors for mem_stage, checked through a scoreboard queue.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  dstn_ex_mm;
  logic [31:0] y_ex_mm;
  logic [31:0] foutput2_ex_mm;
  logic        MemRead_ex_mm, MemWrite_ex_mm, MemtoReg_ex_mm, RegWrite_ex_mm;
  logic [4:0]  dstn_mm_wb;
  logic [31:0] y_mm_wb, rdata_mm_wb, wb_data;
  logic        MemtoReg_mm_wb, RegWrite_mm_wb, misalign_err;
  logic [15:0] store_count;

  typedef struct {
    string       name;
    logic [4:0]  dstn;
    logic [31:0] y;
    logic [31:0] rdata;
    logic        m2r;
    logic        rw;
    logic [31:0] wb;
    logic        mis;
    logic [15:0] sc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .dstn_ex_mm(dstn_ex_mm), .y_ex_mm(y_ex_mm), .foutput2_ex_mm(foutput2_ex_mm),
    .MemRead_ex_mm(MemRead_ex_mm), .MemWrite_ex_mm(MemWrite_ex_mm),
    .MemtoReg_ex_mm(MemtoReg_ex_mm), .RegWrite_ex_mm(RegWrite_ex_mm),
    .dstn_mm_wb(dstn_mm_wb), .y_mm_wb(y_mm_wb), .rdata_mm_wb(rdata_mm_wb),
    .MemtoReg_mm_wb(MemtoReg_mm_wb), .RegWrite_mm_wb(RegWrite_mm_wb),
    .wb_data(wb_data), .misalign_err(misalign_err), .store_count(store_count)
  );

  always #5 clk = ~clk;

  // Drive one instruction for one cycle, then queue its hand-computed MEM/WB result
  task automatic issue(input string name, input logic rst, input logic [4:0] dstn,
                       input logic [31:0] y, input logic [31:0] wd, input logic mr,
                       input logic mw, input logic m2r, input logic rw,
                       input logic [4:0] e_dstn, input logic [31:0] e_y,
                       input logic [31:0] e_rd, input logic e_m2r, input logic e_rw,
                       input logic e_mis, input logic [15:0] e_sc);
    exp_t e;
    @(negedge clk);
    reset = rst; dstn_ex_mm = dstn; y_ex_mm = y; foutput2_ex_mm = wd;
    MemRead_ex_mm = mr; MemWrite_ex_mm = mw; MemtoReg_ex_mm = m2r; RegWrite_ex_mm = rw;
    @(posedge clk);
    #1;
    e.name = name; e.dstn = e_dstn; e.y = e_y; e.rdata = e_rd; e.m2r = e_m2r;
    e.rw = e_rw; e.wb = e_m2r ? e_rd : e_y; e.mis = e_mis; e.sc = e_sc;
    exp_q.push_back(e);
  endtask

  // Monitor: the stage presents a result every cycle; compare it against the queue head
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (dstn_mm_wb !== e.dstn || y_mm_wb !== e.y || rdata_mm_wb !== e.rdata ||
          MemtoReg_mm_wb !== e.m2r || RegWrite_mm_wb !== e.rw || wb_data !== e.wb ||
          misalign_err !== e.mis || store_count !== e.sc) begin
        n_fail++;
        $display("FAIL %s: got dstn=%0d y=%h rd=%h m2r=%b rw=%b wb=%h mis=%b sc=%0d; want dstn=%0d y=%h rd=%h m2r=%b rw=%b wb=%h mis=%b sc=%0d",
                 e.name, dstn_mm_wb, y_mm_wb, rdata_mm_wb, MemtoReg_mm_wb, RegWrite_mm_wb,
                 wb_data, misalign_err, store_count, e.dstn, e.y, e.rdata, e.m2r, e.rw,
                 e.wb, e.mis, e.sc);
      end else begin
        $display("vec %s: dstn=%0d y=%h rd=%h rw=%b wb=%h mis=%b sc=%0d", e.name,
                 dstn_mm_wb, y_mm_wb, rdata_mm_wb, RegWrite_mm_wb, wb_data, misalign_err,
                 store_count);
      end
    end
  end

  initial begin
    reset = 1'b0; dstn_ex_mm = '0; y_ex_mm = '0; foutput2_ex_mm = '0;
    MemRead_ex_mm = 1'b0; MemWrite_ex_mm = 1'b0; MemtoReg_ex_mm = 1'b0; RegWrite_ex_mm = 1'b0;
    // name     rst dstn y            wd           mr mw m2r rw | dstn y            rdata        m2r rw mis sc
    issue("reset0",   0, 5'd3, 32'h20,       32'h99,       0, 1, 1, 1,  5'd0, 32'h0,        32'h0,        0, 0, 0, 16'd0);
    issue("reset1",   0, 5'd1, 32'h24,       32'h0,        1, 0, 1, 1,  5'd0, 32'h0,        32'h0,        0, 0, 0, 16'd0);
    issue("st_dead",  1, 5'd0, 32'h10,       32'hDEADBEEF, 0, 1, 0, 0,  5'd0, 32'h10,       32'h0,        0, 0, 0, 16'd1);
    issue("ld_dead",  1, 5'd7, 32'h10,       32'h0,        1, 0, 1, 1,  5'd7, 32'h10,       32'hDEADBEEF, 1, 1, 0, 16'd1);
    issue("st_one",   1, 5'd0, 32'h4,        32'h1,        0, 1, 0, 0,  5'd0, 32'h4,        32'h0,        0, 0, 0, 16'd2);
    issue("ld_wrap",  1, 5'd8, 32'h404,      32'h0,        1, 0, 1, 1,  5'd8, 32'h404,      32'h1,        1, 1, 0, 16'd2);
    issue("alu_r0",   1, 5'd0, 32'h55,       32'h0,        0, 0, 0, 1,  5'd0, 32'h55,       32'h0,        0, 0, 0, 16'd2);
    issue("alu_r9",   1, 5'd9, 32'h1234,     32'h0,        0, 0, 0, 1,  5'd9, 32'h1234,     32'h0,        0, 1, 0, 16'd2);
    issue("st_A",     1, 5'd0, 32'h8,        32'hA,        0, 1, 0, 0,  5'd0, 32'h8,        32'h0,        0, 0, 0, 16'd3);
    issue("rd_wr",    1, 5'd10,32'h8,        32'hB,        1, 1, 1, 1,  5'd10,32'h8,        32'hA,        1, 1, 0, 16'd4);
    issue("ld_B",     1, 5'd10,32'h8,        32'h0,        1, 0, 1, 1,  5'd10,32'h8,        32'hB,        1, 1, 0, 16'd4);
    issue("st_7",     1, 5'd0, 32'h0,        32'h7,        0, 1, 0, 0,  5'd0, 32'h0,        32'h0,        0, 0, 0, 16'd5);
    issue("rst_st",   0, 5'd3, 32'h0,        32'hF,        0, 1, 0, 1,  5'd0, 32'h0,        32'h0,        0, 0, 0, 16'd0);
    issue("ld_7",     1, 5'd4, 32'h0,        32'h0,        1, 0, 1, 1,  5'd4, 32'h0,        32'h7,        1, 1, 0, 16'd0);
    issue("noread",   1, 5'd2, 32'h10,       32'h0,        0, 0, 1, 1,  5'd2, 32'h10,       32'h0,        1, 1, 0, 16'd0);
    issue("mis_st",   1, 5'd0, 32'h12,       32'h77,       0, 1, 0, 0,  5'd0, 32'h12,       32'h0,        0, 0, 1, 16'd0);
    issue("ld_keep",  1, 5'd6, 32'h10,       32'h0,        1, 0, 1, 1,  5'd6, 32'h10,       32'hDEADBEEF, 1, 1, 1, 16'd0);
    issue("mis_ld",   1, 5'd5, 32'h413,      32'h0,        1, 0, 1, 1,  5'd5, 32'h413,      32'h0,        1, 0, 1, 16'd0);
    for (int i = 0; i < 10; i++) begin
      issue($sformatf("sticky%0d", i), 1, 5'd1, 32'h100 + i, 32'h0, 0, 0, 0, 1,
            5'd1, 32'h100 + i, 32'h0, 0, 1, 1, 16'd0);
    end
    issue("rst_clr",  0, 5'd5, 32'h10,       32'h0,        1, 0, 1, 1,  5'd0, 32'h0,        32'h0,        0, 0, 0, 16'd0);
    issue("post_rst", 1, 5'd11,32'h4,        32'h0,        1, 0, 1, 1,  5'd11,32'h4,        32'h1,        1, 1, 0, 16'd0);
    // Let the monitor drain the last entries; a leftover entry is a miscompare
    repeat (3) @(posedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
